// File: rtl/phase_sequencer.sv
// Frame sequencer stepping N_PH phase blocks through an enable/done handshake with a gap,
// watchdog, sticky timeout flag and frame counter. Define PHASE_SEQ_SKIP_EN to add skip_i.
module phase_sequencer #(
    parameter int N_PH    = 3,
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8,
    parameter int FC_W    = 8,
    localparam int PH_W   = (N_PH <= 2) ? 1 : $clog2(N_PH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            run_i,
    input  logic [N_PH-1:0] done_i,
    input  logic            clr_i,
`ifdef PHASE_SEQ_SKIP_EN
    input  logic [N_PH-1:0] skip_i,
`endif
    output logic [N_PH-1:0] en_o,
    output logic [PH_W-1:0] phase_o,
    output logic            frame_o,
    output logic [FC_W-1:0] frame_cnt_o,
    output logic            timeout_o,
    output logic [PH_W-1:0] err_phase_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, ARM, WAIT, GAP} state_t;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PH - 1);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [PH_W-1:0] phase_reg, phase_next;
    logic [TO_W-1:0] wd_reg, wd_next;
    logic            frame_reg, frame_next;
    logic [FC_W-1:0] fcnt_reg, fcnt_next;
    logic            timeout_reg, timeout_next;
    logic [PH_W-1:0] err_reg, err_next;

    logic [N_PH-1:0] phase_onehot;
    logic            done_sel;
    logic            advance;

    // Decoded phase select; also used to pick this phase's done (and skip) bit.
    generate
        for (genvar gi = 0; gi < N_PH; gi++) begin : g_onehot
            assign phase_onehot[gi] = (phase_reg == PH_W'(gi));
        end
    endgenerate

    assign done_sel = |(done_i & phase_onehot);

`ifdef PHASE_SEQ_SKIP_EN
    logic skip_sel;
    assign skip_sel = |(skip_i & phase_onehot);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            wd_reg      <= '0;
            frame_reg   <= 1'b0;
            fcnt_reg    <= '0;
            timeout_reg <= 1'b0;
            err_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            wd_reg      <= wd_next;
            frame_reg   <= frame_next;
            fcnt_reg    <= fcnt_next;
            timeout_reg <= timeout_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        wd_next      = wd_reg;
        frame_next   = 1'b0;
        fcnt_next    = fcnt_reg;
        timeout_next = timeout_reg;
        err_next     = err_reg;
        advance      = 1'b0;

        // Clear first so a simultaneous timeout below overrides it.
        if (clr_i) begin
            timeout_next = 1'b0;
            err_next     = '0;
        end

        case (state_reg)
            IDLE: begin
                if (run_i) begin
                    state_next = ARM;
                    phase_next = '0;
                end
            end
            ARM: begin
                wd_next    = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (done_sel) begin
                    advance = 1'b1;
                end else if ((TIMEOUT != 0) && (wd_reg == TO_LAST)) begin
                    advance      = 1'b1;
                    timeout_next = 1'b1;
                    if (!timeout_reg || clr_i) begin
                        err_next = phase_reg;
                    end
                end else begin
                    wd_next = wd_reg + TO_W'(1);
                end
            end
            GAP: begin
                if ((phase_reg == '0) && !run_i) begin
                    state_next = IDLE;
`ifdef PHASE_SEQ_SKIP_EN
                end else if (skip_sel) begin
                    advance = 1'b1;
`endif
                end else begin
                    state_next = ARM;
                end
            end
            default: state_next = IDLE;
        endcase

        // Completion (or skip) moves to the next index and always passes through GAP.
        if (advance) begin
            state_next = GAP;
            if (phase_reg == PH_LAST) begin
                phase_next = '0;
                frame_next = 1'b1;
                fcnt_next  = fcnt_reg + FC_W'(1);
            end else begin
                phase_next = phase_reg + PH_W'(1);
            end
        end
    end

    assign en_o        = ((state_reg == ARM) || (state_reg == WAIT)) ? phase_onehot : '0;
    assign phase_o     = phase_reg;
    assign frame_o     = frame_reg;
    assign frame_cnt_o = fcnt_reg;
    assign timeout_o   = timeout_reg;
    assign err_phase_o = err_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (N_PH=3, TIMEOUT=16) with a delay-programmable slave model.
module tb_phase_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       run_i;
    logic [2:0] done_i;
    logic       clr_i;
    logic [2:0] en_o;
    logic [1:0] phase_o;
    logic       frame_o;
    logic [7:0] frame_cnt_o;
    logic       timeout_o;
    logic [1:0] err_phase_o;
    logic       busy_o;

    int n_total = 0;
    int n_pass  = 0;

    // Slave model: phase k answers done when its enable has been high for dly[k] edges.
    logic [7:0] en_cnt [3];
    int         dly    [3];
    logic [2:0] hold;

    always #5 clk_i = ~clk_i;

    phase_sequencer #(.N_PH(3), .TIMEOUT(16), .TO_W(8), .FC_W(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run_i),
        .done_i      (done_i),
        .clr_i       (clr_i),
`ifdef PHASE_SEQ_SKIP_EN
        .skip_i      (3'b000),
`endif
        .en_o        (en_o),
        .phase_o     (phase_o),
        .frame_o     (frame_o),
        .frame_cnt_o (frame_cnt_o),
        .timeout_o   (timeout_o),
        .err_phase_o (err_phase_o),
        .busy_o      (busy_o)
    );

    always @(posedge clk_i) begin
        for (int k = 0; k < 3; k++) begin
            en_cnt[k] <= en_o[k] ? en_cnt[k] + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        done_i = 3'b000;
        for (int k = 0; k < 3; k++) begin
            done_i[k] = hold[k] | (en_o[k] && (int'(en_cnt[k]) == dly[k]));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expects n_en cycles of onehot(p) on en_o, then one all-zero GAP cycle.
    task automatic run_phase(input int p, input int n_en, input logic exp_frame);
        for (int c = 0; c < n_en; c++) begin
            chk($sformatf("en_o phase%0d cyc%0d", p, c), 32'(en_o), 32'(1) << p);
            tick();
        end
        chk($sformatf("en_o gap after phase%0d", p), 32'(en_o), 32'd0);
        chk($sformatf("frame_o gap after phase%0d", p), 32'(frame_o), 32'(exp_frame));
        tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        run_i  = 1'b0;
        clr_i  = 1'b0;
        hold   = 3'b000;
        for (int k = 0; k < 3; k++) dly[k] = 2;
        repeat (3) tick();

        chk("reset en_o", 32'(en_o), 32'd0);
        chk("reset busy_o", 32'(busy_o), 32'd0);
        chk("reset phase_o", 32'(phase_o), 32'd0);
        chk("reset frame_o", 32'(frame_o), 32'd0);
        chk("reset frame_cnt_o", 32'(frame_cnt_o), 32'd0);
        chk("reset timeout_o", 32'(timeout_o), 32'd0);
        chk("reset err_phase_o", 32'(err_phase_o), 32'd0);

        // 1: five normal frames, 12 cycles each
        rst_ni = 1'b1;
        run_i  = 1'b1;
        tick();
        chk("busy_o running", 32'(busy_o), 32'd1);
        for (int f = 0; f < 5; f++) begin
            run_phase(0, 3, 1'b0);
            run_phase(1, 3, 1'b0);
            run_phase(2, 3, 1'b1);
        end
        chk("frame_cnt_o after 5 frames", 32'(frame_cnt_o), 32'd5);

        // 2: phase 1 done held high -> ARM + one WAIT cycle only
        hold = 3'b010;
        run_phase(0, 3, 1'b0);
        run_phase(1, 2, 1'b0);
        hold = 3'b000;
        chk("timeout_o after held done", 32'(timeout_o), 32'd0);
        run_phase(2, 3, 1'b1);

        // 3: phase 2 silent -> 17 enable cycles and a timeout
        dly[2] = 1000;
        run_phase(0, 3, 1'b0);
        run_phase(1, 3, 1'b0);
        run_phase(2, 17, 1'b1);
        chk("timeout_o after phase2 timeout", 32'(timeout_o), 32'd1);
        chk("err_phase_o after phase2 timeout", 32'(err_phase_o), 32'd2);
        chk("phase_o restarts at 0", 32'(phase_o), 32'd0);
        dly[2] = 2;
        dly[0] = 1000;
        run_phase(0, 17, 1'b0);
        chk("timeout_o after phase0 timeout", 32'(timeout_o), 32'd1);
        chk("err_phase_o keeps first phase", 32'(err_phase_o), 32'd2);
        dly[0] = 2;
        clr_i = 1'b1;
        run_phase(1, 3, 1'b0);
        clr_i = 1'b0;
        chk("timeout_o after clr", 32'(timeout_o), 32'd0);
        chk("err_phase_o after clr", 32'(err_phase_o), 32'd0);

        // 4: done on the watchdog's last cycle wins
        dly[2] = 16;
        run_phase(2, 17, 1'b1);
        chk("timeout_o done at last wd cycle", 32'(timeout_o), 32'd0);
        dly[2] = 2;

        // 5: run_i dropped mid-frame; frame completes, then IDLE
        run_phase(0, 3, 1'b0);
        run_i = 1'b0;
        run_phase(1, 3, 1'b0);
        run_phase(2, 3, 1'b1);
        chk("idle en_o", 32'(en_o), 32'd0);
        chk("idle busy_o", 32'(busy_o), 32'd0);
        chk("frame_cnt_o after stop", 32'(frame_cnt_o), 32'd9);
        tick();
        chk("idle busy_o held", 32'(busy_o), 32'd0);
        run_i = 1'b1;
        tick();
        chk("restart en_o", 32'(en_o), 32'd1);
        chk("restart phase_o", 32'(phase_o), 32'd0);

        // 6: asynchronous reset during WAIT of phase 1
        run_phase(0, 3, 1'b0);
        tick();
        chk("phase1 WAIT en_o", 32'(en_o), 32'd2);
        rst_ni = 1'b0;
        #1;
        chk("async rst en_o", 32'(en_o), 32'd0);
        chk("async rst busy_o", 32'(busy_o), 32'd0);
        chk("async rst phase_o", 32'(phase_o), 32'd0);
        chk("async rst frame_cnt_o", 32'(frame_cnt_o), 32'd0);
        chk("async rst timeout_o", 32'(timeout_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("post-release en_o", 32'(en_o), 32'd0);
        tick();
        chk("post-release restart en_o", 32'(en_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
